// File: rtl/nn_pkg.sv
// Shared definitions for the fully connected layer stages.
// Provides layer dimensions, the output vector type passed from the MAC
// stage to the bias stage, the MAC state encoding and a saturating
// accumulate helper (used when DENSE_MAC_SAT_EN is defined).
package nn_pkg;

  localparam int unsigned N_OUT  = 10;
  localparam int unsigned N_IN   = 784;
  localparam int unsigned DATA_W = 32;

  localparam longint SAT_MAX = 64'sd2147483647;
  localparam longint SAT_MIN = -64'sd2147483648;

  // One 32-bit signed value per neuron.
  typedef int vec_t [N_OUT];

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } mac_state_e;

  // Add a 64-bit product to a 32-bit accumulator and clamp to int range.
  function automatic int sat_add32(input int a, input longint b);
    longint s;
    s = longint'(a) + b;
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
    end
    return DATA_W'(s);
  endfunction

endpackage

// File: rtl/dense_mac_if.sv
// Feature-beat / output-vector bus of the dense MAC stage.
//   in_valid/in_ready : beat handshake carrying in_data and weight column in_w
//   out_valid/out_ready : result handshake carrying the summed vector out
// master = upstream/downstream environment, slave = the MAC stage.
interface dense_mac_if;
  import nn_pkg::*;

  logic in_valid;
  logic in_ready;
  int   in_data;
  vec_t in_w;
  logic out_valid;
  logic out_ready;
  vec_t out;

  modport master (
    output in_valid, in_data, in_w, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_data, in_w, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/mac_lane.sv
// Single-neuron accumulator of the dense MAC stage.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : drop the partial sum
//   acc_en     : a beat is accepted this cycle
//   last       : the accepted beat completes the vector
//   x, w       : feature value and this lane's weight
//   out_q      : registered final sum, updated only on vector completion
// Macro DENSE_MAC_SAT_EN selects saturating 64-bit accumulate; otherwise
// 32-bit wrap-around arithmetic.
module mac_lane
  import nn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic acc_en,
  input  logic last,
  input  int   x,
  input  int   w,
  output int   out_q
);

  int acc_q;
  int sum_c;

  // Next partial sum including the current beat.
`ifdef DENSE_MAC_SAT_EN
  always_comb sum_c = sat_add32(acc_q, longint'(x) * longint'(w));
`else
  always_comb sum_c = acc_q + x * w;
`endif

  // Accumulator and result registers; the final sum bypasses acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (acc_en) begin
      if (last) begin
        out_q <= sum_c;
        acc_q <= '0;
      end else begin
        acc_q <= sum_c;
      end
    end
  end

endmodule

// File: rtl/dense_mac.sv
// Sequential multiply-accumulate stage of the fully connected layer.
// Accepts one feature plus its N_OUT-wide weight column per beat and
// presents the N_OUT weighted sums after N_IN beats.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous abort of the vector in progress
//   bus        : dense_mac_if.slave (beat input, result vector output)
// Macro DENSE_MAC_SAT_EN enables saturating accumulation in every lane.
module dense_mac #(
  parameter int unsigned N_IN = nn_pkg::N_IN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  dense_mac_if.slave  bus
);
  import nn_pkg::*;

  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept_c;
  logic             last_c;

  // State, beat counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Next state; clear overrides everything and discards a coincident beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    if (clear) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            accept_c = 1'b1;
            if (cnt_q == CNT_W'(N_IN - 1)) begin
              last_c  = 1'b1;
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // One independent accumulator per neuron.
  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    mac_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .acc_en (accept_c),
      .last   (last_c),
      .x      (bus.in_data),
      .w      (bus.in_w[i]),
      .out_q  (bus.out[i])
    );
  end

endmodule

// File: tb/tb_dense_mac.sv
// Self-checking bench for dense_mac: an N_IN=4 instance for most scenarios
// and an N_IN=1 instance for the single-beat vector case. Expected sums come
// from a plain-arithmetic reference model of the accepted beats.
module tb_dense_mac;
  import nn_pkg::*;

  localparam int unsigned NA = 4;
`ifdef DENSE_MAC_SAT_EN
  localparam int OVF0 = 32'sh7fffffff;
  localparam int OVF1 = 32'sh80000000;
`else
  localparam int OVF0 = 0;
  localparam int OVF1 = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
  int   in_data = 0;
  vec_t in_w;
  vec_t exp_v;
  vec_t hold_v;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_vld_cyc = 0;

  dense_mac_if ifa ();
  dense_mac_if ifb ();

  assign ifa.in_valid  = in_valid && !sel;
  assign ifa.in_data   = in_data;
  assign ifa.in_w      = in_w;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid && sel;
  assign ifb.in_data   = in_data;
  assign ifb.in_w      = in_w;
  assign ifb.out_ready = out_ready;

  dense_mac #(.N_IN(NA)) u_dut_a (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa));
  dense_mac #(.N_IN(1))  u_dut_b (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(want));
    end
  endtask

  function automatic logic rdy();
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic logic vld();
    return sel ? ifb.out_valid : ifa.out_valid;
  endfunction

  function automatic int outl(input int i);
    return sel ? ifb.out[i] : ifa.out[i];
  endfunction

  function automatic vec_t rand_w();
    vec_t v;
    for (int i = 0; i < N_OUT; i++) v[i] = $urandom;
    return v;
  endfunction

  function automatic vec_t const_w(input int k, input int step);
    vec_t v;
    for (int i = 0; i < N_OUT; i++) v[i] = k + step * i;
    return v;
  endfunction

  // Reference: each lane is the running sum of x*w over accepted beats.
  function automatic void model_add(input int x, input vec_t w);
    for (int i = 0; i < N_OUT; i++) begin
`ifdef DENSE_MAC_SAT_EN
      longint s;
      s = longint'(exp_v[i]) + longint'(x) * longint'(w[i]);
      if (s > SAT_MAX) s = SAT_MAX;
      if (s < SAT_MIN) s = SAT_MIN;
      exp_v[i] = int'(s);
`else
      exp_v[i] = exp_v[i] + x * w[i];
`endif
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_OUT; i++) exp_v[i] = 0;
  endfunction

  // Offer one beat, wait (bounded) for acceptance, optionally idle afterwards.
  task automatic send_beat(input int x, input vec_t w, input int gap);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_data  = x;
    in_w     = w;
    while (!rdy() && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!rdy()) begin
      chk("ready_timeout", 32'(rdy()), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model_add(x, w);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Called right after the last beat's edge: check the vector, stall, hand off.
  task automatic collect(input int stall, input bit release_out);
    last_vld_cyc = cyc;
    chk("out_valid_lat", 32'(vld()), 1);
    chk("in_ready_done", 32'(rdy()), 0);
    for (int i = 0; i < N_OUT; i++) chk($sformatf("out[%0d]", i), outl(i), exp_v[i]);
    hold_v = exp_v;
    model_reset();
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      in_w      = rand_w();
      repeat (stall) begin @(posedge clk); #1; end
      chk("stall_valid", 32'(vld()), 1);
      chk("stall_ready", 32'(rdy()), 0);
      for (int i = 0; i < N_OUT; i++) chk($sformatf("stall_out[%0d]", i), outl(i), hold_v[i]);
      out_ready = 1'b1;
    end
    if (release_out) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("handoff_valid", 32'(vld()), 0);
      chk("handoff_ready", 32'(rdy()), 1);
    end
  endtask

  task automatic rand_vec(input int n, input int max_gap, input int stall);
    for (int b = 0; b < n; b++) send_beat($urandom, rand_w(), (b == n - 1) ? 0 : $urandom_range(max_gap, 0));
    collect(stall, 1'b1);
  endtask

  initial begin
    int t0;
    vec_t w;
    model_reset();
    in_w = const_w(0, 0);

    // Reset values
    #12;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_out0", ifa.out[0], 0);
    chk("rst_out9", ifa.out[9], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(ifa.in_ready), 1);
    chk("rel_out_valid", 32'(ifa.out_valid), 0);

    // Directed vector, contiguous beats, out_ready high
    for (int b = 1; b <= 4; b++) send_beat(b, const_w(0, 1), 0);
    collect(0, 1'b1);
    chk("dir_out9", ifa.out[9], 90);
    chk("dir_out3", ifa.out[3], 30);

    // Same vector with 2-cycle gaps and a 5-cycle downstream stall
    for (int b = 1; b <= 4; b++) send_beat(b, const_w(0, 1), (b == 4) ? 0 : 2);
    collect(5, 1'b1);
    chk("gap_out9", ifa.out[9], 90);

    // Random vectors with random gaps and stalls
    for (int v = 0; v < 3; v++) rand_vec(NA, 2, $urandom_range(3, 0));

    // Overflow on lanes 0 and 1
    w = const_w(0, 0);
    w[0] = 2;
    w[1] = -2;
    send_beat(32'sh40000000, w, 0);
    send_beat(32'sh40000000, w, 0);
    send_beat(0, rand_w(), 0);
    send_beat(0, rand_w(), 0);
    collect(0, 1'b1);
    chk("ovf_out0", ifa.out[0], OVF0);
    chk("ovf_out1", ifa.out[1], OVF1);

    // clear after 2 beats with a coincident beat; out must survive
    send_beat($urandom, rand_w(), 0);
    send_beat($urandom, rand_w(), 0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = $urandom;
    in_w = rand_w();
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("clr_out_valid", 32'(ifa.out_valid), 0);
    chk("clr_in_ready", 32'(ifa.in_ready), 1);
    chk("clr_out_kept", ifa.out[0], hold_v[0]);
    for (int b = 0; b < 4; b++) send_beat(1, const_w(1, 0), 0);
    collect(0, 1'b1);
    chk("clr_out3", ifa.out[3], 4);

    // Reset mid-vector
    send_beat($urandom, rand_w(), 0);
    send_beat($urandom, rand_w(), 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(ifa.out_valid), 0);
    chk("rst_mid_out0", ifa.out[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(ifa.in_ready), 1);
    // Reset during DONE
    for (int b = 0; b < 4; b++) send_beat($urandom, rand_w(), 0);
    out_ready = 1'b0;
    chk("pre_rst_valid", 32'(ifa.out_valid), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_done_valid", 32'(ifa.out_valid), 0);
    chk("rst_done_out5", ifa.out[5], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rand_vec(NA, 0, 0);

    // Back-to-back vectors: one per N_IN+1 cycles
    for (int b = 0; b < 4; b++) send_beat($urandom, rand_w(), 0);
    collect(0, 1'b0);
    t0 = last_vld_cyc;
    for (int b = 0; b < 4; b++) send_beat($urandom, rand_w(), 0);
    collect(0, 1'b1);
    chk("b2b_period", last_vld_cyc - t0, NA + 1);

    // N_IN=1: every beat completes a vector
    sel = 1'b1;
    for (int v = 0; v < 3; v++) begin
      send_beat($urandom, rand_w(), 0);
      collect($urandom_range(2, 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
